// File: rtl/imm_extend_unit.sv
// -----------------------------------------------------------------------------
// imm_extend_unit
//
// One-stage decoder that extracts and extends the immediate field of a 16-bit
// instruction. An optional EXTEND prefix (op[15:11] = 11110) supplies the upper
// 11 bits of a 16-bit immediate for the following instruction.
//
// Parameters
//   DATA_W  width of the extended immediate (>= 16)
//   EXT_EN  1: honour EXTEND prefixes, 0: treat 11110 as a plain instruction
//
// Ports
//   clk          single rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous flush: drops output, prefix and current input
//   in_valid     instr is valid
//   in_ready     unit accepts instr this cycle (combinational)
//   instr        16-bit instruction word
//   out_valid    output register holds a decoded instruction
//   out_ready    downstream consumes the output this cycle
//   out_instr    accepted instruction (never the prefix)
//   out_imm      extended immediate
//   out_imm_vld  instruction carries an immediate
//   out_extended immediate was formed from an EXTEND prefix
//   out_ext_err  prefix was followed by a non-immediate instruction
// -----------------------------------------------------------------------------
module imm_extend_unit #(
   parameter int DATA_W = 16,
   parameter bit EXT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_instr,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_imm_vld,
   output logic              out_extended,
   output logic              out_ext_err
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PFX  = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_S8   = 3'd1,
      CLS_S4   = 3'd2,
      CLS_S11  = 3'd3,
      CLS_S5   = 3'd4,
      CLS_SH   = 3'd5,
      CLS_U8   = 3'd6
   } imm_class_t;

   // Immediate class of an instruction word.
   function automatic imm_class_t classify(input logic [15:0] w);
      imm_class_t c;
      c = CLS_NONE;
      case (w[15:11])
         5'b01001, 5'b00100, 5'b00101, 5'b10010, 5'b11010: c = CLS_S8;
         // Only two sub-opcodes of 01100 carry a signed imm8.
         5'b01100: c = ((w[10:8] == 3'b011) || (w[10:8] == 3'b000)) ? CLS_S8 : CLS_NONE;
         5'b01000: c = (w[4] == 1'b0) ? CLS_S4 : CLS_NONE;
         5'b00010: c = CLS_S11;
         5'b10011, 5'b11011: c = CLS_S5;
         5'b00110: c = CLS_SH;
         5'b01101, 5'b01011: c = CLS_U8;
         default: c = CLS_NONE;
      endcase
      return c;
   endfunction

   // Immediate of an unprefixed instruction, extended to DATA_W.
   function automatic logic [DATA_W-1:0] plain_imm(input imm_class_t c, input logic [15:0] w);
      logic [DATA_W-1:0] v;
      v = '0;
      case (c)
         CLS_S8:  v = DATA_W'($signed(w[7:0]));
         CLS_S4:  v = DATA_W'($signed(w[3:0]));
         CLS_S11: v = DATA_W'($signed(w[10:0]));
         CLS_S5:  v = DATA_W'($signed(w[4:0]));
         // A zero shift field encodes a shift of eight.
         CLS_SH:  v = (w[4:2] == 3'b000) ? DATA_W'(4'd8) : DATA_W'(w[4:2]);
         CLS_U8:  v = DATA_W'(w[7:0]);
         default: v = '0;
      endcase
      return v;
   endfunction

   // Immediate formed from a stored prefix plus the low five bits of the word.
   function automatic logic [DATA_W-1:0] prefixed_imm(input imm_class_t c,
                                                      input logic [10:0] pfx,
                                                      input logic [15:0] w);
      logic [15:0]       imm16;
      logic [DATA_W-1:0] v;
      imm16 = {pfx[4:0], pfx[10:5], w[4:0]};
      case (c)
         CLS_NONE:       v = '0;
         CLS_SH, CLS_U8: v = DATA_W'(imm16);
         default:        v = DATA_W'($signed(imm16));
      endcase
      return v;
   endfunction

   state_t            state_r;
   logic [10:0]       pfx_r;
   imm_class_t        cls_s;
   logic              accept_s;
   logic              is_pfx_s;
   logic [DATA_W-1:0] nxt_imm_s;
   logic              nxt_vld_s;
   logic              nxt_ext_s;
   logic              nxt_err_s;

   // Accept whenever not flushing and the output slot is free or being drained.
   assign in_ready = !flush && (!out_valid || out_ready);

   // Decode the presented instruction into its next output values.
   always_comb begin
      cls_s     = classify(instr);
      accept_s  = in_valid && in_ready;
      is_pfx_s  = EXT_EN && (instr[15:11] == 5'b11110);
      nxt_vld_s = (cls_s != CLS_NONE);
      if (state_r == PFX) begin
         nxt_imm_s = prefixed_imm(cls_s, pfx_r, instr);
         nxt_ext_s = (cls_s != CLS_NONE);
         nxt_err_s = (cls_s == CLS_NONE);
      end else begin
         nxt_imm_s = plain_imm(cls_s, instr);
         nxt_ext_s = 1'b0;
         nxt_err_s = 1'b0;
      end
   end

   // Prefix FSM and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         pfx_r        <= 11'd0;
         out_valid    <= 1'b0;
         out_instr    <= 16'd0;
         out_imm      <= '0;
         out_imm_vld  <= 1'b0;
         out_extended <= 1'b0;
         out_ext_err  <= 1'b0;
      end else if (flush) begin
         state_r   <= IDLE;
         out_valid <= 1'b0;
      end else if (accept_s) begin
         if (is_pfx_s) begin
            // Prefix is absorbed; any previous output was consumed this cycle.
            state_r   <= PFX;
            pfx_r     <= instr[10:0];
            out_valid <= 1'b0;
         end else begin
            state_r      <= IDLE;
            out_valid    <= 1'b1;
            out_instr    <= instr;
            out_imm      <= nxt_imm_s;
            out_imm_vld  <= nxt_vld_s;
            out_extended <= nxt_ext_s;
            out_ext_err  <= nxt_err_s;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: tb/tb_imm_extend_unit.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_unit
//
// Scoreboard bench for imm_extend_unit (DATA_W=32, EXT_EN=1). A driver issues
// directed and randomized instructions, predicts each output from an
// arithmetic reference model and queues it; an independent monitor compares
// the DUT output against the queue head every cycle the output is valid.
// -----------------------------------------------------------------------------
module tb_imm_extend_unit;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   instr;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_instr;
   logic [DW-1:0] out_imm;
   logic          out_imm_vld;
   logic          out_extended;
   logic          out_ext_err;

   imm_extend_unit #(.DATA_W(DW), .EXT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_imm(out_imm), .out_imm_vld(out_imm_vld),
      .out_extended(out_extended), .out_ext_err(out_ext_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] ins;
      logic [31:0] imm;
      logic        vld;
      logic        ext;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   bit          m_ov  = 1'b0;   // model: output register occupied
   bit          m_pv  = 1'b0;   // model: prefix held
   logic [10:0] m_pfx = 11'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Signed value of the low w bits of v.
   function automatic longint sx(input longint v, input int w);
      longint m;
      m = longint'(1) << w;
      v = v & (m - 1);
      if (v >= (m >> 1)) v = v - m;
      return v;
   endfunction

   // Reference: expected output for instruction w given the prefix state.
   function automatic exp_t model(input logic [15:0] w, input bit pv, input logic [10:0] pfx);
      exp_t   e;
      int     op5;
      int     op8;
      int     kind;   // 0 none, 1 signed, 2 unsigned
      longint raw;
      longint p;
      longint wl;
      longint r16;
      wl   = longint'(w);
      op5  = int'(wl >> 11);
      op8  = int'(wl >> 8);
      kind = 0;
      raw  = 0;
      if (op5 inside {9, 4, 5, 18, 26} || op8 == 99 || op8 == 96) begin
         kind = 1; raw = sx(wl, 8);
      end else if (op5 == 8 && ((wl >> 4) & 1) == 0) begin
         kind = 1; raw = sx(wl, 4);
      end else if (op5 == 2) begin
         kind = 1; raw = sx(wl, 11);
      end else if (op5 inside {19, 27}) begin
         kind = 1; raw = sx(wl, 5);
      end else if (op5 == 6) begin
         kind = 2; raw = (wl >> 2) & 7;
         if (raw == 0) raw = 8;
      end else if (op5 inside {13, 11}) begin
         kind = 2; raw = wl & 255;
      end
      e.ins = w;
      e.vld = (kind != 0);
      e.ext = 1'b0;
      e.err = 1'b0;
      if (pv) begin
         p   = longint'(pfx);
         r16 = (p & 31) * 2048 + (p >> 5) * 32 + (wl & 31);
         if (kind == 0) begin
            e.err = 1'b1;
         end else begin
            e.ext = 1'b1;
            raw   = (kind == 1) ? sx(r16, 16) : r16;
         end
      end
      e.imm = raw[31:0];
      return e;
   endfunction

   // One cycle of stimulus; the model follows the handshake it predicts.
   task automatic step(input bit v, input logic [15:0] ins, input bit rdy, input bit fl);
      bit   er;
      bit   acc;
      exp_t e;
      @(posedge clk);
      #1;
      in_valid  = v;
      instr     = ins;
      out_ready = rdy;
      flush     = fl;
      @(negedge clk);
      #2;
      er = !fl && (!m_ov || rdy);
      chk("in_ready", {63'd0, in_ready}, {63'd0, er});
      acc = v && er;
      if (fl) begin
         m_ov = 1'b0;
         m_pv = 1'b0;
         sb.delete();
      end else if (acc) begin
         if (ins[15:11] == 5'b11110) begin
            m_pfx = ins[10:0];
            m_pv  = 1'b1;
            m_ov  = 1'b0;
         end else begin
            e = model(ins, m_pv, m_pfx);
            sb.push_back(e);
            m_pv = 1'b0;
            m_ov = 1'b1;
         end
      end else if (m_ov && rdy) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic chk_out(input string name, input logic [31:0] imm, input bit vld,
                          input bit ext, input bit err);
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({name, "_imm"}, {32'd0, out_imm}, {32'd0, imm});
      chk({name, "_flags"}, {61'd0, out_imm_vld, out_extended, out_ext_err},
          {61'd0, vld, ext, err});
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b0;
      #2;
      chk("reset_outputs",
          {12'd0, out_valid, out_instr, out_imm, out_imm_vld, out_extended, out_ext_err},
          64'd0);
      sb.delete();
      m_ov = 1'b0;
      m_pv = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Monitor: output must match the scoreboard head while valid.
   always @(negedge clk) begin
      if (rst) begin
         chk("out_valid", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
         if (out_valid && sb.size() != 0) begin
            chk("out_instr", {48'd0, out_instr}, {48'd0, sb[0].ins});
            chk("out_imm", {32'd0, out_imm}, {32'd0, sb[0].imm});
            chk("out_flags", {61'd0, out_imm_vld, out_extended, out_ext_err},
                {61'd0, sb[0].vld, sb[0].ext, sb[0].err});
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      int          ops[16] = '{9, 4, 5, 18, 26, 8, 2, 19, 27, 6, 13, 11, 30, 30, 12, 28};
      logic [15:0] ins;
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      instr     = 16'd0;
      out_ready = 1'b1;
      #2;
      chk("reset_outputs_init",
          {12'd0, out_valid, out_instr, out_imm, out_imm_vld, out_extended, out_ext_err},
          64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Directed examples.
      step(1'b1, 16'h48F0, 1'b1, 1'b0); step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("s8_neg", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h68F0, 1'b1, 1'b0); step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("u8", 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h3000, 1'b1, 1'b0); step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("shift8", 32'h0000_0008, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'hE000, 1'b1, 1'b0); step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("no_imm", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hF222, 1'b1, 1'b0); step(1'b1, 16'h4814, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("ext", 32'h0000_1234, 1'b1, 1'b1, 1'b0);
      step(1'b1, 16'hF222, 1'b1, 1'b0); step(1'b1, 16'hE000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("ext_err", 32'h0000_0000, 1'b0, 1'b0, 1'b1);

      // Backpressure then back-to-back flow.
      step(1'b1, 16'h48F0, 1'b1, 1'b0);
      step(1'b1, 16'h68F0, 1'b0, 1'b0);
      step(1'b1, 16'h68F0, 1'b0, 1'b0);
      step(1'b1, 16'h68F0, 1'b1, 1'b0);
      step(1'b1, 16'h3000, 1'b1, 1'b0);
      chk_out("no_bubble1", 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("no_bubble2", 32'h0000_0008, 1'b1, 1'b0, 1'b0);

      // Flush and reset discard a held prefix.
      step(1'b1, 16'hF222, 1'b1, 1'b0); step(1'b1, 16'h4814, 1'b1, 1'b1);
      step(1'b1, 16'h4814, 1'b1, 1'b0); step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("flush_pfx", 32'h0000_0014, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'hF222, 1'b1, 1'b0);
      reset_pulse();
      step(1'b1, 16'h4814, 1'b1, 1'b0); step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_out("rst_pfx", 32'h0000_0014, 1'b1, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            ins = 16'($urandom);
         end else begin
            ins = {5'(ops[$urandom_range(0, 15)]), 11'($urandom)};
         end
         if (i == 300) reset_pulse();
         step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      end

      // Drain.
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("drain", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 DATA_W, 16, width of out_imm; SHALL be legal for any value >= 16.
REQ-002 EXT_EN, 1, when 1 the unit SHALL honour EXTEND (11110) prefixes; when 0, 11110 SHALL be an ordinary non-immediate instruction.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 flush  in  1  synchronous pipeline flush, highest priority after reset.
REQ-006 in_valid  in  1  instr is valid.
REQ-007 in_ready  out  1  unit accepts instr this cycle.
REQ-008 instr  in  16  16-bit instruction word.
REQ-009 out_valid  out  1  output register holds a decoded instruction.
REQ-010 out_ready  in  1  downstream consumes the output this cycle.
REQ-011 out_instr  out  16  registered copy of the accepted instruction (not the prefix).
REQ-012 out_imm  out  DATA_W  extended immediate.
REQ-013 out_imm_vld  out  1  instruction carries an immediate.
REQ-014 out_extended  out  1  immediate was formed from an EXTEND prefix.
REQ-015 out_ext_err  out  1  prefix was followed by a non-immediate instruction.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal !flush && (!out_valid || out_ready), so throughput is one instruction per cycle with no bubble.
REQ-018 Latency SHALL be one cycle: an instruction accepted at edge N SHALL appear on the outputs after edge N.
REQ-019 Output registers SHALL hold stable while out_valid && !out_ready.
REQ-020 Signed imm8 class: op[15:11] in {01001, 00100, 00101, 10010, 11010} or op[15:8] in {01100011, 01100000}; imm = sext(instr[7:0]).
REQ-021 Signed imm4 class: op[15:11]=01000 and instr[4]=0; imm = sext(instr[3:0]).
REQ-022 Signed imm11 class: op[15:11]=00010; imm = sext(instr[10:0]).
REQ-023 Signed imm5 class: op[15:11] in {10011, 11011}; imm = sext(instr[4:0]).
REQ-024 Shift class: op[15:11]=00110; imm = zext(instr[4:2]), except instr[4:2]=000 SHALL give 8.
REQ-025 Unsigned imm8 class: op[15:11] in {01101, 01011}; imm = zext(instr[7:0]).
REQ-026 Any other instruction SHALL give out_imm=0 and out_imm_vld=0; every listed class SHALL give out_imm_vld=1.
REQ-027 Extension SHALL fill all DATA_W bits (sext replicates the MSB of the field; zext fills with zeros).
REQ-028 FSM states SHALL be IDLE and PFX; reset and flush SHALL enter IDLE.
REQ-029 In IDLE with EXT_EN=1, accepting op[15:11]=11110 SHALL store instr[10:0], enter PFX, and produce no output.
REQ-030 In PFX, accepting another 11110 SHALL replace the stored prefix, stay in PFX, and produce no output.
REQ-031 In PFX, accepting an immediate-class instruction SHALL output imm16={pfx[4:0], pfx[10:5], instr[4:0]}, extended to DATA_W (zext for shift and unsigned classes, sext otherwise), set out_extended=1, and return to IDLE.
REQ-032 In PFX, accepting a non-immediate instruction SHALL output it with out_imm=0, out_imm_vld=0, out_ext_err=1, and return to IDLE.
REQ-033 flush SHALL, at the next edge, clear out_valid, discard any held prefix, and drop any input presented that cycle.
REQ-034 When the output is consumed and nothing new is accepted, out_valid SHALL fall to 0 at the next edge.

Reset
REQ-035 While rst=0: out_valid, out_instr, out_imm, out_imm_vld, out_extended and out_ext_err SHALL be 0, and the FSM SHALL be in IDLE, irrespective of clk.
REQ-036 Reset asserted in PFX SHALL discard the prefix; the first instruction after reset SHALL be decoded as unextended.

Verification
REQ-037 DATA_W=32, out_ready=1, instr 0x48F0 -> next cycle out_imm=0xFFFFFFF0, out_imm_vld=1, out_extended=0.
REQ-038 instr 0x68F0 -> out_imm=0x00F0; instr 0x3000 -> out_imm=0x0008; instr 0xE000 -> out_imm_vld=0, out_imm=0.
REQ-039 instr 0xF222 then 0x4814 -> no output after the prefix, then out_imm=0x1234, out_extended=1; 0xF222 then 0xE000 -> out_ext_err=1.
REQ-040 out_ready=0 for 2 cycles with out_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> next instruction follows with no bubble.
REQ-041 0xF222, flush, then 0x4814 -> out_imm=0x0014, out_extended=0; repeat with rst pulse instead of flush -> same result.
